// File: rtl/keymem_req_arbiter.sv
// Round-robin arbiter sharing one keymem key lookup port among NUM_PATHS
// network paths; one request in flight, with per-request timeout and error pulse.
module keymem_req_arbiter #(
  parameter int NUM_PATHS      = 4,
  parameter int KEY_ID_WIDTH   = 32,
  parameter int KEY_WIDTH      = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              key_clk,
  input  logic                              key_aresetn,
  input  logic [NUM_PATHS-1:0]              ch_key_req,
  input  logic [NUM_PATHS*KEY_ID_WIDTH-1:0] ch_key_id,
  output logic [NUM_PATHS-1:0]              ch_key_ack,
  output logic [NUM_PATHS-1:0]              ch_key_err,
  output logic [KEY_WIDTH-1:0]              ch_key,
  output logic                              key_req,
  output logic [KEY_ID_WIDTH-1:0]           key_id,
  input  logic                              key_ack,
  input  logic [KEY_WIDTH-1:0]              key,
  output logic                              busy,
  output logic [15:0]                       timeout_count
);

  // state | meaning
  // IDLE  | waiting for any path request; grant chosen round-robin
  // ISSUE | key_req pulse to keymem, wait counter cleared
  // WAIT  | waiting for key_ack or timeout
  // DONE  | ack or err pulse to the granted path

  localparam int GW = $clog2(NUM_PATHS);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           last_q, last_d;
  logic [KEY_ID_WIDTH-1:0] key_id_q, key_id_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0]    ch_key_q, ch_key_d;
  logic [NUM_PATHS-1:0]    ack_q, ack_d;
  logic [NUM_PATHS-1:0]    err_q, err_d;
  logic [15:0]             timeout_count_q, timeout_count_d;

  logic [1:0]              rst_sync_q;
  logic                    rst_n;
  logic                    found;
  logic [GW-1:0]           pick;
  logic [GW:0]             cand;
  logic [NUM_PATHS-1:0]    grant_oh;
  logic [KEY_ID_WIDTH-1:0] id_arr [NUM_PATHS];

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge key_clk or negedge key_aresetn) begin
    if (!key_aresetn) rst_sync_q <= 2'b00;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_comb begin
    for (int p = 0; p < NUM_PATHS; p++) begin
      id_arr[p] = ch_key_id[p*KEY_ID_WIDTH +: KEY_ID_WIDTH];
    end
  end

  // Scan from last grant + 1 upward; wrap by compare so any NUM_PATHS works.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = '0;
    for (int i = 1; i <= NUM_PATHS; i++) begin
      cand = {1'b0, last_q} + (GW+1)'(i);
      if (cand >= (GW+1)'(NUM_PATHS)) cand = cand - (GW+1)'(NUM_PATHS);
      if (!found && ch_key_req[cand[GW-1:0]]) begin
        found = 1'b1;
        pick  = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    grant_oh         = '0;
    grant_oh[last_q] = 1'b1;
  end

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    key_id_d        = key_id_q;
    cnt_d           = cnt_q;
    ch_key_d        = ch_key_q;
    ack_d           = '0;
    err_d           = '0;
    timeout_count_d = timeout_count_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          last_d   = pick;
          key_id_d = id_arr[pick];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (key_ack) begin
          ch_key_d = key;
          ack_d    = grant_oh;
          state_d  = DONE;
        end else if (cnt_q == WAIT_LAST) begin
          err_d   = grant_oh;
          state_d = DONE;
          if (timeout_count_q != 16'hFFFF) timeout_count_d = timeout_count_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge key_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      last_q          <= GW'(NUM_PATHS - 1);
      key_id_q        <= '0;
      cnt_q           <= '0;
      ch_key_q        <= '0;
      ack_q           <= '0;
      err_q           <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      last_q          <= last_d;
      key_id_q        <= key_id_d;
      cnt_q           <= cnt_d;
      ch_key_q        <= ch_key_d;
      ack_q           <= ack_d;
      err_q           <= err_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign key_req       = (state_q == ISSUE);
  assign busy          = (state_q != IDLE);
  assign key_id        = key_id_q;
  assign ch_key        = ch_key_q;
  assign ch_key_ack    = ack_q;
  assign ch_key_err    = err_q;
  assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_keymem_req_arbiter.sv
// Directed and randomized bench for keymem_req_arbiter against a
// transaction-level round-robin/timeout model.
module tb_keymem_req_arbiter;

  localparam int TMO = 8;

  logic         key_clk = 1'b0;
  logic         key_aresetn = 1'b1;
  logic [3:0]   ch_key_req = '0;
  logic [127:0] ch_key_id = '0;
  logic [3:0]   ch_key_ack;
  logic [3:0]   ch_key_err;
  logic [255:0] ch_key;
  logic         key_req;
  logic [31:0]  key_id;
  logic         key_ack = 1'b0;
  logic [255:0] key = '0;
  logic         busy;
  logic [15:0]  timeout_count;

  int checks = 0;
  int failures = 0;

  int           last_g;
  logic [3:0]   pend;
  logic [31:0]  ids [4];
  logic [255:0] exp_ch_key;
  int           exp_tmo;

  keymem_req_arbiter #(
    .NUM_PATHS(4), .KEY_ID_WIDTH(32), .KEY_WIDTH(256), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .key_clk(key_clk), .key_aresetn(key_aresetn),
    .ch_key_req(ch_key_req), .ch_key_id(ch_key_id),
    .ch_key_ack(ch_key_ack), .ch_key_err(ch_key_err), .ch_key(ch_key),
    .key_req(key_req), .key_id(key_id), .key_ack(key_ack), .key(key),
    .busy(busy), .timeout_count(timeout_count)
  );

  always #5 key_clk = ~key_clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int rr_pick(input int last, input logic [3:0] p);
    for (int i = 1; i <= 4; i++) begin
      if (p[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    ch_key_req = pend;
    for (int p = 0; p < 4; p++) ch_key_id[p*32 +: 32] = ids[p];
  endtask

  task automatic add_req(input int p);
    if (!pend[p]) begin
      ids[p]  = $urandom;
      pend[p] = 1'b1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_key_req"}, key_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_key_id"}, key_id, 0);
    chk({tag, "_ack"}, ch_key_ack, 0);
    chk({tag, "_err"}, ch_key_err, 0);
    chk({tag, "_ch_key"}, ch_key, 0);
    chk({tag, "_tmo_count"}, timeout_count, 0);
  endtask

  task automatic do_reset();
    key_aresetn = 1'b0;
    key_ack     = 1'b0;
    pend        = '0;
    drive_reqs();
    @(posedge key_clk); #1;
    chk_all_zero("reset");
    key_aresetn = 1'b1;
    repeat (4) @(posedge key_clk);
    #1;
    last_g     = 3;
    exp_ch_key = '0;
    exp_tmo    = 0;
  endtask

  // Called just after the edge starting an IDLE cycle with pend driven.
  task automatic txn(input int delay, input logic [255:0] kv, input bit keep);
    int         g;
    int         ackc;
    int         endc;
    bit         tmo;
    logic [3:0] oh;
    g    = rr_pick(last_g, pend);
    oh   = 4'b0001 << g;
    tmo  = (delay > TMO);
    ackc = 1 + delay;
    endc = tmo ? TMO + 2 : ackc + 1;
    @(negedge key_clk);
    chk("idle_key_req", key_req, 0);
    chk("idle_busy", busy, 0);
    @(posedge key_clk); #1;
    @(negedge key_clk);
    chk("issue_key_req", key_req, 1);
    chk("issue_key_id", key_id, ids[g]);
    chk("issue_busy", busy, 1);
    last_g = g;
    for (int c = 2; c < endc; c++) begin
      @(posedge key_clk); #1;
      key_ack = (c == ackc);
      key     = (c == ackc) ? kv : rand256();
      @(negedge key_clk);
      chk("wait_key_req", key_req, 0);
      chk("wait_ack", ch_key_ack, 0);
      chk("wait_err", ch_key_err, 0);
      chk("wait_key_id", key_id, ids[g]);
    end
    @(posedge key_clk); #1;
    key_ack = 1'b0;
    key     = rand256();
    @(negedge key_clk);
    if (!tmo) begin
      exp_ch_key = kv;
      chk("done_ack", ch_key_ack, oh);
      chk("done_err", ch_key_err, 0);
    end else begin
      if (exp_tmo < 65535) exp_tmo++;
      chk("done_err", ch_key_err, oh);
      chk("done_ack", ch_key_ack, 0);
    end
    chk("done_ch_key", ch_key, exp_ch_key);
    chk("done_tmo_count", timeout_count, exp_tmo);
    chk("done_busy", busy, 1);
    @(posedge key_clk); #1;
    if (!keep) pend[g] = 1'b0;
    drive_reqs();
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge key_clk);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ack"}, ch_key_ack, 0);
    chk({tag, "_err"}, ch_key_err, 0);
    @(posedge key_clk); #1;
  endtask

  initial begin
    int p;
    for (int i = 0; i < 4; i++) ids[i] = '0;
    #3;
    do_reset();

    // single request from path 2
    ids[2] = 32'h0000_0005;
    pend   = 4'b0100;
    drive_reqs();
    txn(4, {32{8'hA5}}, 1'b0);
    idle_cycle("single_after");

    // contention: all paths request continuously
    do_reset();
    for (int i = 0; i < 4; i++) add_req(i);
    drive_reqs();
    for (int n = 0; n < 5; n++) txn($urandom_range(1, 4), rand256(), 1'b1);

    // fairness: after path 2, paths 0 and 3 together
    do_reset();
    add_req(2);
    drive_reqs();
    txn(2, rand256(), 1'b0);
    add_req(0);
    add_req(3);
    drive_reqs();
    txn(3, rand256(), 1'b0);
    txn(1, rand256(), 1'b0);

    // timeout, then a late key_ack in IDLE
    add_req(1);
    drive_reqs();
    txn(100, rand256(), 1'b0);
    idle_cycle("tmo_idle");
    key_ack = 1'b1;
    key     = rand256();
    idle_cycle("late_ack");
    key_ack = 1'b0;
    @(negedge key_clk);
    chk("late_ack_ch_key", ch_key, exp_ch_key);
    chk("late_ack_tmo_count", timeout_count, exp_tmo);
    @(posedge key_clk); #1;

    // key_ack on the last WAIT cycle wins over timeout
    add_req(3);
    drive_reqs();
    txn(TMO, rand256(), 1'b0);

    // timeout counter saturation
    force dut.timeout_count_q = 16'hFFFF;
    @(posedge key_clk); #1;
    release dut.timeout_count_q;
    exp_tmo = 65535;
    add_req(0);
    drive_reqs();
    txn(TMO + 1, rand256(), 1'b0);

    // reset in the middle of WAIT
    add_req(1);
    drive_reqs();
    repeat (3) @(posedge key_clk);
    #4;
    key_aresetn = 1'b0;
    #1;
    chk_all_zero("midwait_rst");
    pend = '0;
    drive_reqs();
    @(posedge key_clk); #1;
    key_aresetn = 1'b1;
    last_g     = 3;
    exp_ch_key = '0;
    exp_tmo    = 0;
    repeat (3) @(posedge key_clk);
    #1;
    key_ack = 1'b1;
    key     = rand256();
    idle_cycle("rst_late_ack");
    key_ack = 1'b0;
    @(negedge key_clk);
    chk("rst_late_ch_key", ch_key, 0);
    @(posedge key_clk); #1;
    add_req(1);
    add_req(0);
    drive_reqs();
    txn(2, rand256(), 1'b0);
    txn(3, rand256(), 1'b0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      p = $urandom_range(0, 3);
      add_req(p);
      if ($urandom_range(0, 1) == 1) begin
        p = $urandom_range(0, 3);
        add_req(p);
      end
      drive_reqs();
      txn($urandom_range(1, TMO + 3), rand256(), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
